// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: read ports, two write ports, reservation and bulk-clear control.
interface register_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 3
);
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_busy;
  logic                         wa_en;
  logic [ADDR_WIDTH-1:0]        wa_addr;
  logic [DATA_WIDTH-1:0]        wa_data;
  logic                         wb_en;
  logic [ADDR_WIDTH-1:0]        wb_addr;
  logic [DATA_WIDTH-1:0]        wb_data;
  logic                         rsv_en;
  logic [ADDR_WIDTH-1:0]        rsv_addr;
  logic                         clr_req;
  logic                         clr_busy;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           rsv_en, rsv_addr, clr_req,
    input  rd_data, rd_busy, clr_busy
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           rsv_en, rsv_addr, clr_req,
    output rd_data, rd_busy, clr_busy
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file with dual write ports, optional write-to-read bypass,
// pending-write scoreboard and a sequenced bulk clear.
//
// state | meaning
// IDLE  | normal operation, writes and reservations accepted
// CLEAR | one register (and its busy bit) zeroed per cycle, writes/reservations blocked
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 3,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input logic               clk,
  input logic               rst,
  register_file_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]       busy_q;
  logic                   wa_eff, wb_eff, rsv_eff;

  assign wa_eff  = (state_q == IDLE) && bus.wa_en  && !((ZERO_REG != 0) && (bus.wa_addr  == '0));
  assign wb_eff  = (state_q == IDLE) && bus.wb_en  && !((ZERO_REG != 0) && (bus.wb_addr  == '0));
  assign rsv_eff = (state_q == IDLE) && bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // B is applied after A so it wins on an address collision; reserve is applied last so it wins over a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      busy_q <= '0;
    end else if (state_q == CLEAR) begin
      mem[cnt_q]    <= '0;
      busy_q[cnt_q] <= 1'b0;
    end else begin
      if (wa_eff) mem[bus.wa_addr] <= bus.wa_data;
      if (wb_eff) mem[bus.wb_addr] <= bus.wb_data;
      if (wa_eff) busy_q[bus.wa_addr] <= 1'b0;
      if (wb_eff) busy_q[bus.wb_addr] <= 1'b0;
      if (rsv_eff) busy_q[bus.rsv_addr] <= 1'b1;
    end
  end

  assign bus.clr_busy = (state_q == CLEAR);

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
    logic                  b;
    logic                  hit;

    assign a = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      d   = mem[a];
      b   = busy_q[a];
      hit = 1'b0;
      if (BYPASS != 0) begin
        if (wb_eff && (bus.wb_addr == a)) begin
          d   = bus.wb_data;
          hit = 1'b1;
        end else if (wa_eff && (bus.wa_addr == a)) begin
          d   = bus.wa_data;
          hit = 1'b1;
        end
      end
      // A forwarded write retires the pending producer unless a new one is reserved in the same cycle.
      if (hit && !(rsv_eff && (bus.rsv_addr == a))) b = 1'b0;
      if (rst || ((ZERO_REG != 0) && (a == '0))) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
    assign bus.rd_busy[i] = b;
  end
endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: BYPASS=1 and BYPASS=0 instances driven in lockstep
// and compared against a behavioural model of the register file.
module tb_register_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] rd_addr;
  logic             wa_en, wb_en, rsv_en, clr_req;
  logic [AW-1:0]    wa_addr, wb_addr, rsv_addr;
  logic [DW-1:0]    wa_data, wb_data;

  register_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) if1 ();
  register_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) if0 ();

  assign if1.rd_addr = rd_addr;  assign if0.rd_addr = rd_addr;
  assign if1.wa_en = wa_en;      assign if0.wa_en = wa_en;
  assign if1.wa_addr = wa_addr;  assign if0.wa_addr = wa_addr;
  assign if1.wa_data = wa_data;  assign if0.wa_data = wa_data;
  assign if1.wb_en = wb_en;      assign if0.wb_en = wb_en;
  assign if1.wb_addr = wb_addr;  assign if0.wb_addr = wb_addr;
  assign if1.wb_data = wb_data;  assign if0.wb_data = wb_data;
  assign if1.rsv_en = rsv_en;    assign if0.rsv_en = rsv_en;
  assign if1.rsv_addr = rsv_addr; assign if0.rsv_addr = rsv_addr;
  assign if1.clr_req = clr_req;  assign if0.clr_req = clr_req;

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(0), .ZERO_REG(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));

  int tests = 0;
  int fails = 0;

  // Reference model: register contents, pending bits, clear progress.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_clr;
  int            m_cnt;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rda(input int i);
    logic [NR*AW-1:0] v;
    v = rd_addr;
    return v[i*AW +: AW];
  endfunction

  function automatic bit m_wr_hit(input logic [AW-1:0] a);
    if (rst || m_clr || a == 0) return 0;
    return (wb_en && wb_addr == a) || (wa_en && wa_addr == a);
  endfunction

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a, input bit byp);
    if (rst || a == 0) return '0;
    if (byp && !m_clr) begin
      if (wb_en && wb_addr == a) return wb_data;
      if (wa_en && wa_addr == a) return wa_data;
    end
    return m_mem[a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin m_mem[k] = '0; m_busy[k] = 0; end
    m_clr = 0;
    m_cnt = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_clr) begin
      m_mem[m_cnt] = '0;
      m_busy[m_cnt] = 0;
      m_cnt++;
      if (m_cnt == DEPTH) begin m_clr = 0; m_cnt = 0; end
    end else begin
      if (wa_en && wa_addr != 0) begin m_mem[wa_addr] = wa_data; m_busy[wa_addr] = 0; end
      if (wb_en && wb_addr != 0) begin m_mem[wb_addr] = wb_data; m_busy[wb_addr] = 0; end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1;
      if (clr_req) begin m_clr = 1; m_cnt = 0; end
    end
  endtask

  task automatic check_model();
    logic [AW-1:0] a;
    bit            eb;
    for (int i = 0; i < NR; i++) begin
      a = rda(i);
      chk($sformatf("byp1_data%0d@%0d", i, a), if1.rd_data[i*DW +: DW], m_rd(a, 1));
      chk($sformatf("byp0_data%0d@%0d", i, a), if0.rd_data[i*DW +: DW], m_rd(a, 0));
      eb = (rst || a == 0) ? 1'b0 : m_busy[a];
      chk($sformatf("byp0_busy%0d@%0d", i, a), {31'b0, if0.rd_busy[i]}, {31'b0, eb});
      if (!(m_wr_hit(a) && rsv_en && rsv_addr == a)) begin
        if (m_wr_hit(a)) eb = 0;
        chk($sformatf("byp1_busy%0d@%0d", i, a), {31'b0, if1.rd_busy[i]}, {31'b0, eb});
      end
    end
    chk("clr_busy1", {31'b0, if1.clr_busy}, {31'b0, (m_clr && !rst)});
    chk("clr_busy0", {31'b0, if0.clr_busy}, {31'b0, (m_clr && !rst)});
  endtask

  task automatic to_neg();
    @(negedge clk);
    check_model();
  endtask

  task automatic to_pos();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    to_neg();
    to_pos();
  endtask

  task automatic idle_in();
    wa_en = 0; wb_en = 0; rsv_en = 0; clr_req = 0;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic fill_all();
    for (int r = 1; r < DEPTH; r++) begin
      wa_en = 1; wa_addr = AW'(r);
      wa_data = (r == 20) ? 32'h0BADF00D : ($urandom() | 32'h1);
      step();
    end
    idle_in();
  endtask

  task automatic run_clear(input bit mid_write, output int n);
    clr_req = 1;
    step();
    clr_req = 0;
    n = 0;
    while (if1.clr_busy && n < 100) begin
      if (mid_write && n == 10) begin wa_en = 1; wa_addr = 4; wa_data = 32'h44444444; end
      else wa_en = 0;
      step();
      n++;
    end
    idle_in();
  endtask

  int n;

  initial begin
    rst = 1;
    idle_in();
    wa_addr = '0; wb_addr = '0; rsv_addr = '0; wa_data = '0; wb_data = '0;
    set_rd(1, 2, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    rst = 0;

    // Dual write to distinct registers
    wa_en = 1; wa_addr = 1; wa_data = 32'hDEADBEEF;
    wb_en = 1; wb_addr = 2; wb_data = 32'hCAFEBABE;
    step();
    idle_in();
    chk("dual_p0", if1.rd_data[0 +: DW], 32'hDEADBEEF);
    chk("dual_p1", if1.rd_data[DW +: DW], 32'hCAFEBABE);
    chk("dual_p2", if1.rd_data[2*DW +: DW], 32'h0);

    // Collision: B wins; R0 write ignored
    wa_en = 1; wa_addr = 5; wa_data = 32'h11111111;
    wb_en = 1; wb_addr = 5; wb_data = 32'h22222222;
    step();
    idle_in();
    set_rd(5, 0, 0);
    #1 chk("collide_r5", if1.rd_data[0 +: DW], 32'h22222222);
    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF;
    step();
    idle_in();
    chk("r0_data", if1.rd_data[0 +: DW] & 32'h0 | if1.rd_data[DW +: DW], 32'h0);
    chk("r0_busy", {31'b0, if1.rd_busy[1]}, 32'h0);

    // Bypass versus stored read
    wa_en = 1; wa_addr = 1; wa_data = 32'h12345678;
    step();
    idle_in();
    set_rd(1, 0, 0);
    wb_en = 1; wb_addr = 1; wb_data = 32'h99999999;
    to_neg();
    chk("bypass1_pre", if1.rd_data[0 +: DW], 32'h99999999);
    chk("bypass0_pre", if0.rd_data[0 +: DW], 32'h12345678);
    to_pos();
    idle_in();
    #1;
    chk("bypass0_post", if0.rd_data[0 +: DW], 32'h99999999);

    // Scoreboard
    set_rd(3, 0, 0);
    rsv_en = 1; rsv_addr = 3;
    step();
    idle_in();
    chk("rsv_busy", {31'b0, if1.rd_busy[0]}, 32'h1);
    wa_en = 1; wa_addr = 3; wa_data = 32'hA5A5A5A5;
    step();
    idle_in();
    chk("wr_clears_busy", {31'b0, if1.rd_busy[0]}, 32'h0);
    wa_en = 1; wa_addr = 3; wa_data = 32'hA5A5A5A5; rsv_en = 1; rsv_addr = 3;
    step();
    idle_in();
    chk("rsv_wins_busy", {31'b0, if1.rd_busy[0]}, 32'h1);
    chk("rsv_wins_data", if1.rd_data[0 +: DW], 32'hA5A5A5A5);

    // Bulk clear with a blocked write mid-way
    fill_all();
    rsv_en = 1; rsv_addr = 7;
    step();
    idle_in();
    run_clear(1, n);
    chk("clear_len", 32'(n), 32'd32);
    for (int r = 0; r < DEPTH; r++) begin
      set_rd(r, r, r);
      #1;
      chk($sformatf("post_clr_data%0d", r), if1.rd_data[0 +: DW], 32'h0);
      chk($sformatf("post_clr_busy%0d", r), {31'b0, if1.rd_busy[0]}, 32'h0);
    end

    // Reset in the middle of a clear
    fill_all();
    clr_req = 1;
    step();
    clr_req = 0;
    repeat (10) step();
    set_rd(20, 20, 0);
    #1 chk("r20_before_rst", if1.rd_data[0 +: DW], 32'h0BADF00D);
    rst = 1;
    model_reset();
    wb_en = 1; wb_addr = 20; wb_data = 32'h77777777;
    #1;
    chk("rst_clr_busy", {31'b0, if1.clr_busy}, 32'h0);
    chk("rst_rd_zero", if1.rd_data[0 +: DW], 32'h0);
    step();
    idle_in();
    rst = 0;
    #1 chk("r20_after_rst", if1.rd_data[0 +: DW], 32'h0);
    run_clear(0, n);
    chk("clear_len_after_rst", 32'(n), 32'd32);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      wa_en = $urandom_range(0, 1); wa_addr = AW'($urandom_range(0, 31)); wa_data = $urandom();
      wb_en = $urandom_range(0, 1); wb_addr = AW'($urandom_range(0, 31)); wb_data = $urandom();
      if ($urandom_range(0, 3) == 0) wb_addr = wa_addr;
      rsv_en = ($urandom_range(0, 2) == 0); rsv_addr = AW'($urandom_range(0, 31));
      clr_req = ($urandom_range(0, 149) == 0);
      rd_addr = NR*AW'($urandom());
      if ($urandom_range(0, 1) == 1) rd_addr[AW-1:0] = wb_addr;
      step();
    end
    idle_in();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the core register file: NUM_RD asynchronous read ports and two synchronous write ports (A, B).
- Optional same-cycle write-to-read bypass.
- Per-register pending-write scoreboard for hazard detection.
- Sequenced bulk-clear state machine.
- Sits between decode (reads, reservations) and writeback (write ports) in the pipelined core.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH
NUM_RD, 3, number of read ports (>=1)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = read returns stored value
ZERO_REG, 1, 1 = register 0 hardwired to zero (writes/reservations to addr 0 ignored)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
rd_addr  input  NUM_RD*ADDR_WIDTH  read addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  output  NUM_RD*DATA_WIDTH  read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
rd_busy  output  NUM_RD  1 = addressed register has a pending (reserved, unwritten) write
wa_en  input  1  write port A enable
wa_addr  input  ADDR_WIDTH  write port A address
wa_data  input  DATA_WIDTH  write port A data
wb_en  input  1  write port B enable
wb_addr  input  ADDR_WIDTH  write port B address
wb_data  input  DATA_WIDTH  write port B data
rsv_en  input  1  reserve: mark rsv_addr pending
rsv_addr  input  ADDR_WIDTH  register to reserve
clr_req  input  1  start bulk clear (single-cycle pulse or level)
clr_busy  output  1  bulk clear in progress

Behaviour:
- Reset (rst=1, async):
  - All DEPTH registers = 0, all busy bits = 0, FSM = IDLE, clear counter = 0.
  - clr_busy = 0 immediately.
  - rd_data = 0 and rd_busy = 0 for every port while reset is held.
- Reads: combinational, zero latency.
  - rd_data[i] = reg[rd_addr[i]].
  - ZERO_REG=1 and rd_addr[i]=0 -> rd_data[i] = 0 and rd_busy[i] = 0 regardless of state.
- Bypass (BYPASS=1), effective write only (see blocking below):
  - If B writes rd_addr[i] this cycle -> rd_data[i] = wb_data.
  - Else if A writes rd_addr[i] -> rd_data[i] = wa_data.
  - Else stored value.
  - BYPASS=0: stored value until after the edge.
- Writes: committed at posedge when en=1, not blocked, and the address is not 0 under ZERO_REG.
  - A and B to same address in the same cycle -> B's data committed, A's dropped.
  - Distinct addresses -> both committed.
- Scoreboard, one busy bit per register, updated at posedge:
  - Effective write to X clears busy[X].
  - rsv_en sets busy[rsv_addr].
  - Same-cycle reserve and write to X -> busy[X] = 1 (reserve wins: new producer).
  - Reserving an already-busy register keeps it busy.
  - rd_busy[i] = busy[rd_addr[i]], except BYPASS=1 with an effective write hitting rd_addr[i] this cycle: rd_busy[i] = 0 unless rsv_en targets the same address.
- Clear FSM, states IDLE, CLEAR:
  - IDLE -> CLEAR on posedge with clr_req=1; counter loaded to 0.
  - CLEAR: each posedge, reg[cnt] = 0 and busy[cnt] = 0, cnt increments.
  - When cnt = DEPTH-1 is cleared -> IDLE and cnt wraps to 0. Exactly DEPTH cycles in CLEAR.
  - clr_busy = 1 while in CLEAR, as a registered state decode; it rises the cycle after clr_req is sampled.
  - clr_req while in CLEAR is ignored; no restart or extension.
  - During CLEAR, writes and reservations are blocked: no commit, no bypass, no busy change.
  - Reads during CLEAR return current contents: not-yet-cleared entries keep old values.
  - Reset during CLEAR -> immediate IDLE, everything zero.

Test Plan:
- Reset then write A R1=32'hDEADBEEF, B R2=32'hCAFEBABE in the same cycle -> next cycle port0 (addr 1) = DEADBEEF, port1 (addr 2) = CAFEBABE, port2 (addr 0) = 0.
- A and B both write R5, A=32'h11111111, B=32'h22222222 -> R5 = 22222222. Write R0=32'hFFFFFFFF -> reads 0, rd_busy 0.
- BYPASS=1: R1 = 12345678; in one cycle wb writes R1=99999999 while rd_addr0=1 -> rd_data0 = 99999999 before the edge. BYPASS=0 instance -> 12345678 before the edge, 99999999 after.
- Reserve R3 -> rd_busy = 1 next cycle; write R3=32'hA5A5A5A5 with rsv_en=0 -> busy 0 after the edge. Same-cycle reserve and write R3 -> busy stays 1, data = A5A5A5A5.
- Fill R1..R31 with nonzero values, reserve R7, pulse clr_req -> clr_busy high for 32 cycles. A write to R4 mid-clear is dropped. Afterwards all regs read 0 and all busy bits are 0.
- Assert rst at clear cycle 10, with R20 still 32'h0BADF00D -> clr_busy = 0 immediately and R20 reads 0. A new clr_req after reset starts a full 32-cycle clear.
